ysyx_23060337_ifu: RTL

//  Instruction fetch unit: front stage of the NPC core. Owns the PC register, issues one

---
 rtl/ysyx_23060337_ifu_pkg.sv | 16 +
 rtl/ysyx_23060337_ifu_if.sv | 40 ++++
 rtl/ysyx_23060337_Reg.sv | 21 ++
 rtl/ysyx_23060337_ifu.sv | 133 +++++++++++++
 4 files changed

// File: rtl/ysyx_23060337_ifu_pkg.sv
// Shared definitions for the instruction fetch unit: state encoding,
// reset PC and fetch geometry.
package ysyx_23060337_ifu_pkg;

    localparam int              DEF_XLEN     = 32;
    localparam logic [31:0]     DEF_RESET_PC = 32'h8000_0000;
    localparam int              INST_W       = 32;
    localparam int              PC_STEP      = 4;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_OUT  = 2'd2
    } state_e;

endpackage

// File: rtl/ysyx_23060337_ifu_if.sv
// Fetch-unit bus bundle: imem request/response, decode handshake and the
// redirect path from execute. The master side is the IFU itself.
interface ysyx_23060337_ifu_if
    import ysyx_23060337_ifu_pkg::*;
#(
    parameter int XLEN = DEF_XLEN
);
    logic              imem_req_valid;
    logic              imem_req_ready;
    logic [XLEN-1:0]   imem_req_addr;
    logic              imem_resp_valid;
    logic [INST_W-1:0] imem_resp_data;
    logic              imem_resp_err;
    logic              out_valid;
    logic              out_ready;
    logic [XLEN-1:0]   out_pc;
    logic [INST_W-1:0] out_inst;
    logic              out_fault;
    logic              redirect_valid;
    logic [XLEN-1:0]   redirect_pc;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready,
        input  imem_resp_valid, imem_resp_data, imem_resp_err,
        output out_valid, out_pc, out_inst, out_fault,
        input  out_ready,
        input  redirect_valid, redirect_pc
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready,
        output imem_resp_valid, imem_resp_data, imem_resp_err,
        input  out_valid, out_pc, out_inst, out_fault,
        output out_ready,
        output redirect_valid, redirect_pc
    );

endinterface

// File: rtl/ysyx_23060337_Reg.sv
// Generic register with write enable and synchronous active-high reset.
module ysyx_23060337_Reg #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_wen,
    input  logic [WIDTH-1:0] i_din,
    output logic [WIDTH-1:0] o_dout
);

    always_ff @(posedge clk) begin
        if (rst) begin
            o_dout <= RESET_VAL;
        end else if (i_wen) begin
            o_dout <= i_din;
        end
    end

endmodule

// File: rtl/ysyx_23060337_ifu.sv
// Instruction fetch unit: owns the PC, keeps one imem fetch in flight and
// hands {pc, inst, fault} to decode; execute may redirect the PC at any time.
module ysyx_23060337_ifu
    import ysyx_23060337_ifu_pkg::*;
#(
    parameter int              XLEN     = DEF_XLEN,
    parameter logic [XLEN-1:0] RESET_PC = DEF_RESET_PC
) (
    input  logic                       clk,
    input  logic                       rst,
    ysyx_23060337_ifu_if.master        io_bus
);

    logic [1:0]        r_state;
    state_e            w_state;
    state_e            w_state_next;
    logic [XLEN-1:0]   r_pc;
    logic [XLEN-1:0]   w_pc_next;
    logic              r_drop;
    logic              w_drop_next;
    logic [XLEN-1:0]   r_out_pc;
    logic [XLEN-1:0]   w_out_pc_next;
    logic [INST_W-1:0] r_out_inst;
    logic [INST_W-1:0] w_out_inst_next;
    logic              r_out_fault;
    logic              w_out_fault_next;
    logic              w_out_wen;
    logic              w_misaligned;
    logic              w_req_valid;
    logic              w_req_fire;
    logic              w_out_valid;
    logic              w_out_fire;

    assign w_state      = state_e'(r_state);
    assign w_misaligned = (r_pc[1:0] != 2'b00);

    // A misaligned PC never reaches imem; it is turned into a fault record instead.
    assign w_req_valid = !rst && (w_state == S_REQ) && !w_misaligned;
    assign w_req_fire  = w_req_valid && io_bus.imem_req_ready;
    assign w_out_valid = !rst && (w_state == S_OUT) && !io_bus.redirect_valid;
    assign w_out_fire  = w_out_valid && io_bus.out_ready;

    assign io_bus.imem_req_valid = w_req_valid;
    assign io_bus.imem_req_addr  = r_pc;
    assign io_bus.out_valid      = w_out_valid;
    assign io_bus.out_pc         = r_out_pc;
    assign io_bus.out_inst       = r_out_inst;
    assign io_bus.out_fault      = r_out_fault;

    always_comb begin
        w_state_next     = w_state;
        w_pc_next        = r_pc;
        w_drop_next      = r_drop;
        w_out_wen        = 1'b0;
        w_out_pc_next    = r_pc;
        w_out_inst_next  = '0;
        w_out_fault_next = 1'b0;

        case (w_state)
            S_REQ: begin
                if (io_bus.redirect_valid) begin
                    w_pc_next = io_bus.redirect_pc;
                    if (w_req_fire) begin
                        w_state_next = S_WAIT;
                        w_drop_next  = 1'b1;
                    end
                end else if (w_misaligned) begin
                    w_out_wen        = 1'b1;
                    w_out_fault_next = 1'b1;
                    w_state_next     = S_OUT;
                end else if (w_req_fire) begin
                    w_state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (io_bus.redirect_valid) begin
                    w_pc_next = io_bus.redirect_pc;
                end
                // A response racing a redirect belongs to the old path and is dropped too.
                if (io_bus.imem_resp_valid) begin
                    if (r_drop || io_bus.redirect_valid) begin
                        w_drop_next  = 1'b0;
                        w_state_next = S_REQ;
                    end else begin
                        w_out_wen        = 1'b1;
                        w_out_fault_next = io_bus.imem_resp_err;
                        w_out_inst_next  = io_bus.imem_resp_err ? '0 : io_bus.imem_resp_data;
                        w_state_next     = S_OUT;
                    end
                end else if (io_bus.redirect_valid) begin
                    w_drop_next = 1'b1;
                end
            end
            S_OUT: begin
                if (io_bus.redirect_valid) begin
                    w_pc_next    = io_bus.redirect_pc;
                    w_state_next = S_REQ;
                end else if (w_out_fire) begin
                    w_pc_next    = r_pc + XLEN'(PC_STEP);
                    w_state_next = S_REQ;
                end
            end
            default: begin
                w_state_next = S_REQ;
            end
        endcase
    end

    ysyx_23060337_Reg #(.WIDTH(2), .RESET_VAL(2'(S_REQ))) u_state (
        .clk(clk), .rst(rst), .i_wen(1'b1), .i_din(w_state_next), .o_dout(r_state)
    );

    ysyx_23060337_Reg #(.WIDTH(XLEN), .RESET_VAL(RESET_PC)) u_pc (
        .clk(clk), .rst(rst), .i_wen(1'b1), .i_din(w_pc_next), .o_dout(r_pc)
    );

    ysyx_23060337_Reg #(.WIDTH(1), .RESET_VAL(1'b0)) u_drop (
        .clk(clk), .rst(rst), .i_wen(1'b1), .i_din(w_drop_next), .o_dout(r_drop)
    );

    ysyx_23060337_Reg #(.WIDTH(XLEN), .RESET_VAL('0)) u_out_pc (
        .clk(clk), .rst(rst), .i_wen(w_out_wen), .i_din(w_out_pc_next), .o_dout(r_out_pc)
    );

    ysyx_23060337_Reg #(.WIDTH(INST_W), .RESET_VAL('0)) u_out_inst (
        .clk(clk), .rst(rst), .i_wen(w_out_wen), .i_din(w_out_inst_next), .o_dout(r_out_inst)
    );

    ysyx_23060337_Reg #(.WIDTH(1), .RESET_VAL(1'b0)) u_out_fault (
        .clk(clk), .rst(rst), .i_wen(w_out_wen), .i_din(w_out_fault_next), .o_dout(r_out_fault)
    );

endmodule
